// File: rtl/exec_unit.sv
// exec_unit: execute-stage consumer of the 5-bit aluctrl code.
// One operation per in_valid/in_ready handshake. ALU ops and MFHI/MFLO
// complete in 1 cycle, MULT/MULTU in 2, DIV/DIVU iterate DIV_CYCLES steps.
// Holds architectural HI/LO and returns results via a one-entry buffer.
// Ports:
//   clk, resetn (async active-low), flush (sync cancel)
//   in_valid/in_ready, aluctrl[4:0], src_a[31:0], src_b[31:0]
//   out_valid/out_ready, result[31:0], overflow
//   hi[31:0], lo[31:0] : committed HI/LO registers
module exec_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  aluctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [4:0] AND_CONTROL   = 5'b00000;
  localparam logic [4:0] OR_CONTROL    = 5'b00001;
  localparam logic [4:0] ADD_CONTROL   = 5'b00010;
  localparam logic [4:0] SUB_CONTROL   = 5'b00110;
  localparam logic [4:0] SLT_CONTROL   = 5'b00111;
  localparam logic [4:0] MFHI_CONTROL  = 5'b01000;
  localparam logic [4:0] MFLO_CONTROL  = 5'b01001;
  localparam logic [4:0] MULT_CONTROL  = 5'b01010;
  localparam logic [4:0] MULTU_CONTROL = 5'b01011;
  localparam logic [4:0] DIV_CONTROL   = 5'b01100;
  localparam logic [4:0] DIVU_CONTROL  = 5'b01101;

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
  } mul_req_t;

  // q shifts the dividend magnitude out while quotient bits shift in
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] d;
    logic [31:0] a_orig;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
  } div_ctx_t;

  state_t        state;
  mul_req_t      mreq;
  div_ctx_t      dctx;
  logic [CW-1:0] cnt;

  logic accept, is_mul, is_div, is_sgn;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (aluctrl == MULT_CONTROL) || (aluctrl == MULTU_CONTROL);
  assign is_div   = (aluctrl == DIV_CONTROL)  || (aluctrl == DIVU_CONTROL);
  assign is_sgn   = (aluctrl == MULT_CONTROL) || (aluctrl == DIV_CONTROL);

  // single-cycle ALU
  logic [31:0] sum, diff, alu_res;
  logic        alu_ovf;
  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluctrl)
      ADD_CONTROL: begin
        alu_res = sum;
        alu_ovf = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
      end
      SUB_CONTROL: begin
        alu_res = diff;
        alu_ovf = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
      end
      AND_CONTROL:  alu_res = src_a & src_b;
      OR_CONTROL:   alu_res = src_a | src_b;
      SLT_CONTROL:  alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      MFHI_CONTROL: alu_res = hi;
      MFLO_CONTROL: alu_res = lo;
      default: ;
    endcase
  end

  // extending to 64 bits makes one unsigned multiply serve both signednesses
  logic [63:0] ext_a, ext_b, prod;
  assign ext_a = mreq.sgn ? {{32{mreq.a[31]}}, mreq.a} : {32'b0, mreq.a};
  assign ext_b = mreq.sgn ? {{32{mreq.b[31]}}, mreq.b} : {32'b0, mreq.b};
  assign prod  = ext_a * ext_b;

  // restoring step; r[31] set means the shifted remainder exceeds 32 bits,
  // which is always >= d, and the 32-bit subtraction still wraps correctly
  logic [31:0] r_sh, r_nx, q_nx, quo, rem;
  logic        ge;
  assign r_sh = {dctx.r[30:0], dctx.q[31]};
  assign ge   = dctx.r[31] || (r_sh >= dctx.d);
  assign r_nx = ge ? (r_sh - dctx.d) : r_sh;
  assign q_nx = {dctx.q[30:0], ge};
  assign quo  = dctx.q_neg ? -q_nx : q_nx;
  assign rem  = dctx.r_neg ? -r_nx : r_nx;

  logic [31:0] mag_a, mag_b;
  assign mag_a = (is_sgn && src_a[31]) ? -src_a : src_a;
  assign mag_b = (is_sgn && src_b[31]) ? -src_b : src_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      mreq      <= '0;
      dctx      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_mul) begin
            mreq  <= '{a: src_a, b: src_b, sgn: is_sgn};
            state <= MUL;
          end else if (is_div) begin
            dctx  <= '{q: mag_a, r: '0, d: mag_b, a_orig: src_a,
                       q_neg: is_sgn && (src_a[31] ^ src_b[31]),
                       r_neg: is_sgn && src_a[31], dz: (src_b == '0)};
            cnt   <= '0;
            state <= DIV;
          end else begin
            result    <= alu_res;
            overflow  <= alu_ovf;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          {hi, lo}  <= prod;
          result    <= '0;
          overflow  <= 1'b0;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        DIV: begin
          dctx.q <= q_nx;
          dctx.r <= r_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DIV_CYCLES - 1)) begin
            lo        <= dctx.dz ? 32'hFFFF_FFFF : quo;
            hi        <= dctx.dz ? dctx.a_orig : rem;
            result    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed literal cases plus randomized
// traffic checked every cycle against a latency/queue-level reference model.
module tb_exec_unit;
  localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010,
                         C_SUB = 5'b00110, C_SLT = 5'b00111, C_MFHI = 5'b01000,
                         C_MFLO = 5'b01001, C_MULT = 5'b01010, C_MULTU = 5'b01011,
                         C_DIV = 5'b01100, C_DIVU = 5'b01101;

  logic        clk, resetn, flush, in_valid, in_ready, out_valid, out_ready, overflow;
  logic [4:0]  aluctrl;
  logic [31:0] src_a, src_b, result, hi, lo;

  exec_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .aluctrl(aluctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_left: edges remaining until a MUL/DIV commits its pending HI/LO
  logic        m_busy, m_ov, m_ovf;
  int          m_left;
  logic [31:0] m_res, m_hi, m_lo, m_phi, m_plo;

  always @(negedge clk) begin
    logic exp_rdy;
    logic [31:0] s;
    longint sa, sb, sq, sr;
    logic [63:0] up;
    if (!resetn) begin
      m_busy = 0; m_left = 0; m_ov = 0; m_res = 0; m_ovf = 0; m_hi = 0; m_lo = 0;
    end
    exp_rdy = !m_busy && (!m_ov || out_ready) && !flush;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("result", result, m_res);
      chk("overflow", overflow, m_ovf);
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("in_ready", in_ready, exp_rdy);
    if (resetn) begin
      if (flush) begin
        m_busy = 0; m_ov = 0;
      end else begin
        if (m_ov && out_ready) m_ov = 0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0; m_hi = m_phi; m_lo = m_plo; m_res = 0; m_ovf = 0; m_ov = 1;
          end
        end else if (in_valid && exp_rdy) begin
          sa = longint'($signed(src_a));
          sb = longint'($signed(src_b));
          m_res = 0; m_ovf = 0;
          case (aluctrl)
            C_ADD: begin s = src_a + src_b; m_res = s;
                     m_ovf = (src_a[31] == src_b[31]) && (s[31] != src_a[31]); end
            C_SUB: begin s = src_a - src_b; m_res = s;
                     m_ovf = (src_a[31] != src_b[31]) && (s[31] != src_a[31]); end
            C_AND:  m_res = src_a & src_b;
            C_OR:   m_res = src_a | src_b;
            C_SLT:  m_res = (sa < sb) ? 32'd1 : 32'd0;
            C_MFHI: m_res = m_hi;
            C_MFLO: m_res = m_lo;
            C_MULT: begin up = 64'(sa * sb); m_phi = up[63:32]; m_plo = up[31:0]; end
            C_MULTU: begin up = {32'b0, src_a} * {32'b0, src_b}; m_phi = up[63:32]; m_plo = up[31:0]; end
            C_DIV, C_DIVU: begin
              if (src_b == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = src_a; end
              else if (aluctrl == C_DIV) begin
                sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0];
              end else begin m_plo = src_a / src_b; m_phi = src_a % src_b; end
            end
            default: ;
          endcase
          if (aluctrl inside {C_MULT, C_MULTU}) begin m_busy = 1; m_left = 1; end
          else if (aluctrl inside {C_DIV, C_DIVU}) begin m_busy = 1; m_left = 32; end
          else m_ov = 1;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output int lat);
    int guard;
    @(posedge clk); #1;
    in_valid = 1; aluctrl = c; src_a = a; src_b = b;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      chk("busy_in_ready", in_ready, 0);
      lat++;
      @(negedge clk);
    end
    if (!out_valid || guard >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL run_op_timeout: op %h never completed", c);
    end
    r = result; o = overflow;
  endtask

  logic [31:0] r;
  logic        o;
  int          lat;
  logic [4:0]  codes [13];

  initial begin
    codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_MFHI, C_MFLO, C_MULT, C_MULTU,
              C_DIV, C_DIVU, 5'b11111, 5'b10000};
    resetn = 1; flush = 0; in_valid = 0; out_ready = 1;
    aluctrl = 0; src_a = 0; src_b = 0;
    #1 resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_result", result, 0);
    resetn = 1;

    run_op(C_ADD, 32'h7FFF_FFFF, 32'h1, r, o, lat);
    chk("add_lat", lat, 0); chk("add_res", r, 32'h8000_0000); chk("add_ovf", o, 1);
    run_op(C_SUB, 32'd5, 32'd7, r, o, lat);
    chk("sub_res", r, 32'hFFFF_FFFE); chk("sub_ovf", o, 0);
    run_op(C_ADD, 32'h8000_0000, 32'hFFFF_FFFF, r, o, lat);
    chk("addneg_res", r, 32'h7FFF_FFFF); chk("addneg_ovf", o, 1);
    run_op(C_SLT, 32'hFFFF_FFFF, 32'd1, r, o, lat);
    chk("slt_res", r, 32'd1);

    // back-to-back stream
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 8); aluctrl = C_ADD; src_a = 32'(i * 3); src_b = 32'd100;
      @(negedge clk);
      if (i < 8) chk("stream_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_res", result, 32'((i - 1) * 3 + 100));
      end
    end

    // backpressure
    @(posedge clk); #1;
    in_valid = 1; aluctrl = C_ADD; src_a = 1; src_b = 2; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_res", result, 32'd3);
    end
    @(posedge clk); #1 out_ready = 1;

    run_op(C_MULT, 32'hFFFF_FFFE, 32'd3, r, o, lat);
    chk("mult_lat", lat, 1); chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(C_MULTU, 32'hFFFF_FFFE, 32'd3, r, o, lat);
    chk("multu_hi", hi, 32'h2); chk("multu_lo", lo, 32'hFFFF_FFFA); chk("multu_res", r, 0);
    run_op(C_MFLO, 0, 0, r, o, lat);
    chk("mflo_res", r, 32'hFFFF_FFFA);
    run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, r, o, lat);
    chk("div_lat", lat, 32); chk("div_lo", lo, 32'hFFFF_FFFD); chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(C_DIVU, 32'd7, 32'd0, r, o, lat);
    chk("divu0_lo", lo, 32'hFFFF_FFFF); chk("divu0_hi", hi, 32'd7);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, o, lat);
    chk("divmin_lo", lo, 32'h8000_0000); chk("divmin_hi", hi, 32'd0);
    run_op(C_DIV, 32'hFFFF_FFFB, 32'd0, r, o, lat);
    chk("div0s_lo", lo, 32'hFFFF_FFFF); chk("div0s_hi", hi, 32'hFFFF_FFFB);

    // preload then flush a divide mid-flight
    run_op(C_MULTU, 32'h66A3_BE81, 32'h2A91_2A91, r, o, lat);
    chk("pre_hi", hi, 32'h1111_1111); chk("pre_lo", lo, 32'h1111_1111);
    @(posedge clk); #1;
    in_valid = 1; aluctrl = C_DIV; src_a = 100; src_b = 3;
    @(posedge clk); #1 in_valid = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
    end
    chk("flush_hi", hi, 32'h1111_1111); chk("flush_lo", lo, 32'h1111_1111);

    // asynchronous reset mid-divide
    @(posedge clk); #1;
    in_valid = 1; aluctrl = C_DIV; src_a = 100; src_b = 3;
    @(posedge clk); #1 in_valid = 0;
    repeat (5) @(posedge clk);
    #1 resetn = 0;
    #1;
    chk("arst_valid", out_valid, 0); chk("arst_res", result, 0);
    chk("arst_ovf", overflow, 0); chk("arst_hi", hi, 0); chk("arst_lo", lo, 0);
    @(posedge clk); #1 resetn = 1;
    repeat (40) @(negedge clk);
    chk("arst_after_lo", lo, 0);

    // unknown code leaves HI/LO alone
    run_op(C_MULT, 32'hFFFF_FFFE, 32'd3, r, o, lat);
    run_op(5'b11111, 32'd5, 32'd6, r, o, lat);
    chk("unk_lat", lat, 0); chk("unk_res", r, 0); chk("unk_ovf", o, 0);
    chk("unk_hi", hi, 32'hFFFF_FFFF); chk("unk_lo", lo, 32'hFFFF_FFFA);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pick [6];
      @(posedge clk); #1;
      pick = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      aluctrl   = codes[$urandom_range(0, 12)];
      src_a     = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      src_b     = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
